// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: hex font (a..g in bits 6..0, active-low) and the blank pattern.
// Pure constants; no timing or flow control involved.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK      = 7'h7F;
    localparam bit         SEG_ACTIVE_LOW = 1'b1;

    localparam logic [6:0] SEG_FONT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to seven-segment decoder; zero latency, no flow control.
module hex_to_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_ACTIVE_LOW ? SEG_FONT[hex] : ~SEG_FONT[hex];

endmodule

// File: rtl/xn_7seg_scan.sv
// N-digit multiplexed common-anode seven-segment driver with double-buffered loading and blanking.
// Pins lag idx/disp by one registered cycle; load is always accepted (no backpressure, last load wins).
module xn_7seg_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS  = 8,
    parameter int DIV_MAX = 100000,
    parameter int DIV_W   = 17
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [4*DIGITS-1:0]   x,
    input  logic                  load,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lzb,
    output logic [6:0]            a_to_g,
    output logic [DIGITS-1:0]     an,
    output logic                  dp,
    output logic                  frame
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIV_W-1:0]    div_cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] pend;
    logic [DIGITS-1:0]   dp_pend;
    logic                pend_v;
    logic [4*DIGITS-1:0] disp;
    logic [DIGITS-1:0]   dp_reg;

    logic       tick;
    logic       last;
    logic       commit;
    logic [3:0] nib;
    logic [6:0] font_seg;
    logic       hi_zero;
    logic       blank;

    assign tick   = (div_cnt == DIV_W'(DIV_MAX - 1));
    assign last   = (idx == IDX_W'(DIGITS - 1));
    assign commit = tick & last;
    assign nib    = disp[4*idx +: 4];

    hex_to_7seg u_dec (
        .hex (nib),
        .seg (font_seg)
    );

    // Blank only when this digit and every more significant one are zero.
    always_comb begin
        hi_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(idx) && disp[4*i +: 4] != 4'h0) begin
                hi_zero = 1'b0;
            end
        end
    end

    assign blank = lzb && (idx != '0) && hi_zero && !dp_reg[idx];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            div_cnt <= '0;
            idx     <= '0;
            pend    <= '0;
            dp_pend <= '0;
            pend_v  <= 1'b0;
            disp    <= '0;
            dp_reg  <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                idx <= last ? '0 : idx + 1'b1;
            end
            // Display data only changes at the frame boundary; a coincident load bypasses the buffer.
            if (commit) begin
                if (load) begin
                    disp   <= x;
                    dp_reg <= dp_in;
                end else if (pend_v) begin
                    disp   <= pend;
                    dp_reg <= dp_pend;
                end
                pend_v <= 1'b0;
            end else if (load) begin
                pend    <= x;
                dp_pend <= dp_in;
                pend_v  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            an     <= '1;
            a_to_g <= SEG_BLANK;
            dp     <= 1'b1;
            frame  <= 1'b0;
        end else begin
            an     <= ~(DIGITS'(1) << idx);
            a_to_g <= blank ? SEG_BLANK : font_seg;
            dp     <= ~dp_reg[idx];
            frame  <= commit;
        end
    end

endmodule

// File: doc/xn_7seg_scan.md
Name: xn_7seg_scan

Overview:
Parametrised N-digit multiplexed seven-segment driver. It is the successor to the fixed 4-digit hex display and drives the board's common-anode digits. It adds:
- a configurable refresh prescaler
- double-buffered, tear-free data loading
- per-digit decimal points
- leading-zero blanking
- a frame-start strobe

It sits between the datapath value to be shown and the board's segment and anode pins.

Parameters:
DIGITS, 8, number of multiplexed digits (2..8); input width is 4*DIGITS.
DIV_MAX, 100000, clk cycles per digit slot (>=2); sets the refresh rate.
DIV_W, 17, prescaler counter width; must satisfy 2**DIV_W >= DIV_MAX.

Ports:
clk  in  1  system clock, rising-edge.
clr  in  1  reset; asynchronous, active-high.
x  in  4*DIGITS  value to display; nibble i drives digit i (digit 0 = rightmost).
load  in  1  one-cycle strobe; captures x.
dp_in  in  DIGITS  decimal-point enables, bit i = digit i, active-high.
lzb  in  1  leading-zero blanking enable.
a_to_g  out  7  segments, bit6=a .. bit0=g, active-low.
an  out  DIGITS  digit enables, active-low, one-hot-low.
dp  out  1  decimal point, active-low.
frame  out  1  one-cycle pulse at each frame commit.

Behaviour:
- Reset (clr=1, async) clears the following:
  - div_cnt=0, idx=0
  - pend=0, pend_v=0, disp=0, dp_reg=0
  - an=all 1, a_to_g=7'h7F, dp=1, frame=0
- Prescaler:
  - div_cnt counts 0..DIV_MAX-1 and wraps to 0.
  - tick = (div_cnt==DIV_MAX-1).
- Digit index:
  - On tick, idx <= (idx==DIGITS-1) ? 0 : idx+1.
  - The scan order is 0,1,..,DIGITS-1,0.
- Load buffering:
  - load=1 sets pend <= x, dp_pend <= dp_in, pend_v <= 1.
  - Commit happens when tick and idx==DIGITS-1 (last slot ends). If pend_v=1, then disp <= pend, dp_reg <= dp_pend, pend_v <= 0.
  - frame=1 for exactly that cycle, whether or not data was pending.
  - Load and commit in the same cycle: bypass, so disp <= x, dp_reg <= dp_in, pend_v <= 0.
  - Multiple loads within a frame: the last one wins.
  - disp never changes mid-frame.
- Output stage (registered; 1-cycle latency from idx/disp to pins). For the current idx:
  - an <= ~(1<<idx)
  - nib = disp[4*idx+:4]
  - a_to_g <= font(nib), or 7'h7F if blanked
  - dp <= ~dp_reg[idx]
- Blanking: digit idx is blanked when all of the following hold:
  - lzb=1
  - idx!=0
  - nibbles idx..DIGITS-1 of disp are all zero
  - dp_reg[idx]=0
- A blanked digit still asserts its anode so that slot timing is uniform; it shows segments off. Digit 0 is never blanked.
- Font (a..g, active-low), standard hex:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- lzb and the blanking decision are sampled combinationally each cycle, not buffered.
- clr asserted mid-frame: everything returns to reset values immediately. Scanning restarts at digit 0 with disp=0 after release.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16-entry font constant array
  - constant SEG_BLANK=7'h7F
  - constant SEG_ACTIVE_LOW=1
- The combinational decoder is one sub-module, hex_to_7seg (in 4 bits, out 7 bits), reusable by other display blocks.
- The prescaler, index, buffering and blanking stay in xn_7seg_scan.

Test Plan:
Use DIGITS=4 and DIV_MAX=4 in all scenarios.
1. Reset, then load with x=16'h1234, dp_in=0, lzb=0. After the first frame pulse, successive slots show an=1110/1101/1011/0111 with a_to_g=1001100(4), 0000110(3), 0010010(2), 1001111(1). Each slot lasts 4 clk and dp=1 throughout.
2. lzb=1 with x=16'h0050: digits 3 and 2 give a_to_g=7F with their anodes still active; digit 1 shows 0100100(5); digit 0 shows 0000001(0). With x=16'h0000, only digit 0 lights, showing 0.
3. lzb=1 with x=16'h0005 and dp_in=4'b0100: digit 2 shows 0000001 with dp=0 (the decimal point defeats blanking); digit 3 is blank.
4. Load 16'hAAAA mid-frame while showing 16'h1234: the remaining slots still show 1234. The new value appears only after frame. A second load of 16'hBEEF in the same frame leaves BEEF displayed.
5. load coincident with the commit cycle, x=16'hC0DE: disp=C0DE on the next cycle (bypass) and pend_v=0.
6. Assert clr asynchronously between clock edges mid-slot: an=1111, a_to_g=7F and dp=1 immediately. After release, digit 0 is the first slot, showing 0.
